// File: rtl/wb_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package wb_sched_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned RID_W  = 5;

    typedef logic [RID_W-1:0] reg_id_t;

    // One writeback request from a long-latency unit
    typedef struct packed {
        logic            valid;
        reg_id_t         rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arb.sv
// Two-way round-robin arbiter; rr_ptr names the preferred requester on contention.
module wb_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = rr_ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // After a grant, point at the unit that was not served
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (|gnt) begin
            rr_ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/wb_scheduler.sv
// Writeback scheduler: shares the register-file write port between the ALU and two
// long-latency units, scoreboards outstanding LL results. Optional checker: WB_SCHED_ERR_EN.
module wb_scheduler
    import wb_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  reg_id_t         issue_rs1,
    input  reg_id_t         issue_rs2,
    input  reg_id_t         issue_rd,
    input  logic            issue_long,
    output logic            issue_stall,
    input  logic            alu_wb_valid,
    input  reg_id_t         alu_wb_rd,
    input  logic [XLEN-1:0] alu_wb_data,
    input  logic            ll0_valid,
    input  reg_id_t         ll0_rd,
    input  logic [XLEN-1:0] ll0_data,
    output logic            ll0_ready,
    input  logic            ll1_valid,
    input  reg_id_t         ll1_rd,
    input  logic [XLEN-1:0] ll1_data,
    output logic            ll1_ready,
    output reg_id_t         rf_rd_id,
    output logic [XLEN-1:0] rf_rd_data,
    output logic            busy,
    output logic            err
);

    localparam int unsigned CNT_W = 4;

    wb_req_t          ll0_req;
    wb_req_t          ll1_req;
    wb_req_t          gnt_req_c;
    logic [NREG-1:1]  sb_q;
    logic [NREG-1:0]  sb_vec;
    logic [CNT_W-1:0] starve_cnt_q;
    logic [1:0]       gnt;
    logic             hazard_c;
    logic             starve_c;
    logic             issue_acc_c;
    logic             alu_own_c;
    logic             ll_grant_c;
    logic             ll_wr_c;
    logic             sb_set_c;

    assign ll0_req = '{valid: ll0_valid, rd: ll0_rd, data: ll0_data};
    assign ll1_req = '{valid: ll1_valid, rd: ll1_rd, data: ll1_data};

    // Register 0 is never scoreboarded
    assign sb_vec      = {sb_q, 1'b0};
    assign hazard_c    = sb_vec[issue_rs1] | sb_vec[issue_rs2] | sb_vec[issue_rd];
    assign starve_c    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
    assign issue_stall = (issue_valid & hazard_c) | starve_c;
    assign issue_acc_c = issue_valid & ~issue_stall;
    assign sb_set_c    = issue_acc_c & issue_long & (issue_rd != '0);
    assign busy        = |sb_q;

    // A write to x0 is a no-op and leaves the port free for LL units
    assign alu_own_c = alu_wb_valid & (alu_wb_rd != '0);

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({ll1_req.valid, ll0_req.valid}),
        .en    (~alu_own_c),
        .gnt   (gnt)
    );

    assign ll0_ready  = gnt[0];
    assign ll1_ready  = gnt[1];
    assign ll_grant_c = |gnt;
    assign gnt_req_c  = gnt[1] ? ll1_req : ll0_req;
    assign ll_wr_c    = ll_grant_c & (gnt_req_c.rd != '0);

    // Write-port mux; an LL grant to x0 naturally yields rf_rd_id = 0
    always_comb begin
        rf_rd_id   = '0;
        rf_rd_data = '0;
        if (alu_own_c) begin
            rf_rd_id   = alu_wb_rd;
            rf_rd_data = alu_wb_data;
        end else if (ll_grant_c) begin
            rf_rd_id   = gnt_req_c.rd;
            rf_rd_data = gnt_req_c.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q <= '0;
        end else begin
            if (ll_wr_c) begin
                sb_q[gnt_req_c.rd] <= 1'b0;
            end
            if (sb_set_c) begin
                sb_q[issue_rd] <= 1'b1;
            end
        end
    end

    // Counts cycles a pending LL request is denied the port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else if (ll_grant_c || !(ll0_valid || ll1_valid)) begin
            starve_cnt_q <= '0;
        end else if (!starve_c) begin
            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
        end
    end

`ifdef WB_SCHED_ERR_EN
    logic err_q;
    logic ll0_pend_q;
    logic ll1_pend_q;
    logic err_set_c;

    always_comb begin
        err_set_c = 1'b0;
        if (alu_own_c && sb_vec[alu_wb_rd]) begin
            err_set_c = 1'b1;
        end
        if (ll_wr_c && !sb_vec[gnt_req_c.rd]) begin
            err_set_c = 1'b1;
        end
        if ((ll0_pend_q && !ll0_valid) || (ll1_pend_q && !ll1_valid)) begin
            err_set_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            ll0_pend_q <= 1'b0;
            ll1_pend_q <= 1'b0;
        end else begin
            err_q      <= err_q | err_set_c;
            ll0_pend_q <= ll0_valid & ~ll0_ready;
            ll1_pend_q <= ll1_valid & ~ll1_ready;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Writeback scheduler for the 32-entry register file: it owns the register file's single write port (`rd_id`/`rd_data`, where index 0 means no write) and shares it between the single-cycle ALU writeback and two long-latency units (LL0 = load/store, LL1 = mul/div). It keeps a scoreboard of registers with outstanding long-latency results and stalls issue on RAW and WAW hazards. A starvation counter guarantees forward progress for the long-latency units.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles a pending LL request may go ungranted before the scheduler forces an issue stall; legal range 1..15.

- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `issue_valid` in 1: decode presents an instruction.
- `issue_rs1` in 5: source register 1 index.
- `issue_rs2` in 5: source register 2 index.
- `issue_rd` in 5: destination register index.
- `issue_long` in 1: the instruction's result returns through LL0 or LL1.
- `issue_stall` out 1: instruction not accepted this cycle; decode holds it.
- `alu_wb_valid` in 1: ALU result present; always accepted, no ready.
- `alu_wb_rd` in 5: ALU destination register.
- `alu_wb_data` in 32: ALU result.
- `ll0_valid` in 1, `ll0_rd` in 5, `ll0_data` in 32: LL0 result request.
- `ll0_ready` out 1: LL0 result written this cycle.
- `ll1_valid` in 1, `ll1_rd` in 5, `ll1_data` in 32: LL1 result request.
- `ll1_ready` out 1: LL1 result written this cycle.
- `rf_rd_id` out 5: drives register file `rd_id`.
- `rf_rd_data` out 32: drives register file `rd_data`.
- `busy` out 1: at least one scoreboard bit is set.
- `err` out 1: sticky protocol-error flag; see Configuration.

## Operation
Scoreboard:
- `sb[31:1]` is a register vector. `sb[0]` does not exist and reads as 0.
- `hazard` = `sb[rs1] | sb[rs2] | sb[rd]`, computed from the registered scoreboard only.
- `issue_stall` = (`issue_valid & hazard`) | `starve`.
- An issue is accepted when `issue_valid & !issue_stall`.
- An accepted issue with `issue_long` and `rd != 0` sets `sb[rd]` at the clock edge.
- An LL grant with `rd != 0` clears `sb[rd]` at the clock edge.
- A set and a clear of the same register cannot occur in the same cycle, because the WAW check already stalls that issue.

Port arbitration (combinational, same cycle):
- The ALU has priority. When `alu_wb_valid` and `alu_wb_rd != 0`, the ALU owns the port and both LL ready outputs are 0.
- Otherwise, the requesting LL unit is granted. If both request, the one selected by `rr_ptr` is granted.
- After each LL grant, `rr_ptr` points to the other unit. `rr_ptr` resets to 0, so LL0 is preferred first.
- An LL grant with `rd == 0` consumes the request without writing (`rf_rd_id = 0`).
- With no grant, `rf_rd_id = 0` and `rf_rd_data = 0`.
- LL units hold `valid`, `rd` and `data` stable until they see `ready`. `ready` may depend combinationally on `valid`.

Starvation:
- `starve_cnt` (4 bits) increments, saturating at `STARVE_LIMIT`, in any cycle where some LL unit is valid but no LL grant occurs.
- It clears on any LL grant, or when neither LL unit is valid.
- `starve` = (`starve_cnt == STARVE_LIMIT`). It stalls issue until the ALU pipeline drains and an LL grant occurs.

`busy` = OR of `sb`.

## Timing
- Reset (asynchronous): `sb` = 0, `rr_ptr` = 0, `starve_cnt` = 0, `err` = 0.
- Output values in reset: `issue_stall` = 0, `busy` = 0, `ll0_ready` = 0, `ll1_ready` = 0, `rf_rd_id` = 0, `rf_rd_data` = 0.
- Write-port path has zero latency: the register file captures the granted data at the same edge as the grant.
- Scoreboard updates become visible to `hazard` one cycle after the issue or grant edge.
- An instruction reading a register written by an LL grant in cycle N may issue in cycle N+1.
- Reset asserted mid-operation clears all state. Outstanding LL requests are then unscoreboarded and must be flushed by their units, which share the same reset.

## Configuration
- `WB_SCHED_ERR_EN` defined: `err` sets, and stays set until reset, in any of these cases:
  - ALU write to a register whose `sb` bit is set.
  - LL grant with `rd != 0` whose `sb` bit is clear.
  - `ll0_valid` or `ll1_valid` drops without a ready.
- `WB_SCHED_ERR_EN` undefined: `err` is tied to 0 and no checking logic is built.

## Structure
- `wb_sched_pkg` contains:
  - typedef `reg_id_t` (`logic [4:0]`);
  - constant `XLEN = 32`;
  - struct `wb_req_t` {`valid`, `rd`, `data`}.
- Sub-module `wb_rr_arb` is a 2-way round-robin arbiter holding `rr_ptr`, with inputs `req[1:0]` and `en`, and output `gnt[1:0]`.

## Test plan
- Reset, then idle: all outputs are 0.
- Issue long with `rd = 5` → `busy` = 1. Next cycle, issue with `rs1 = 5` → `issue_stall` = 1. After `ll0_valid`, `rd = 5`, `data = 0xDEADBEEF`: `rf_rd_id = 5`, `rf_rd_data = 0xDEADBEEF`, `ll0_ready` = 1. The following cycle, `issue_stall` = 0 and `busy` = 0.
- ALU `rd = 3` and LL1 `rd = 7` in the same cycle → `rf_rd_id = 3` and `ll1_ready` = 0. Next cycle, with the ALU idle → `rf_rd_id = 7` and `ll1_ready` = 1.
- LL0 and LL1 both valid for 4 cycles with the ALU idle → grants go LL0, LL1, LL0, LL1.
- ALU writes `rd = 1` every cycle while LL0 is valid, with `STARVE_LIMIT` = 4 → `issue_stall` = 1 from the 5th cycle. Once the ALU stops, LL0 is granted and the stall drops the next cycle.
- With `WB_SCHED_ERR_EN` defined: set `sb[9]`, then an ALU write to `rd = 9` → `err` = 1 next cycle and stays 1 until reset. Issue with `rd = 0` and `issue_long` → `sb` is unchanged.
